// File: rtl/md_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package md_pkg;

    localparam int unsigned ITER = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } md_state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_result_t;

endpackage : md_pkg

// File: rtl/md_iter_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module md_iter_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] qr,
    input  logic [WIDTH-1:0] mag,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] qr_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // Multiply: {acc,qr} holds product-high and the multiplier shifting out LSB first.
    // Divide: acc is the partial remainder, qr the dividend/quotient shift register.
    always_comb begin
        acc_next = acc;
        qr_next  = qr;
        sum      = {1'b0, acc} + (qr[0] ? {1'b0, mag} : {(WIDTH + 1){1'b0}});
        rem_sh   = {acc, qr[WIDTH-1]};
        diff     = rem_sh - {1'b0, mag};
        if (is_div) begin
            // Top bit of the 33-bit difference is the borrow.
            if (!diff[WIDTH]) begin
                acc_next = diff[WIDTH-1:0];
                qr_next  = {qr[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = rem_sh[WIDTH-1:0];
                qr_next  = {qr[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = sum[WIDTH:1];
            qr_next  = {sum[0], qr[WIDTH-1:1]};
        end
    end

endmodule : md_iter_step

// File: rtl/md_unit.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit feeding architectural HI/LO.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] qr_q;
    logic [WIDTH-1:0] mag_b_q;
    logic [WIDTH-1:0] a_orig_q;
    logic             is_div_q;
    logic             neg_q_q;
    logic             neg_r_q;
    logic             dz_q;

    logic             is_signed;
    logic             is_div_op;
    logic             is_md_op;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0] qr_nx;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // Operand decode and magnitude extraction at issue time.
    always_comb begin
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        is_div_op = (op == OP_DIV) || (op == OP_DIVU);
        is_md_op  = (op == OP_MULT) || (op == OP_MULTU) || is_div_op;
        mag_a     = (is_signed && a[WIDTH-1]) ? (-a) : a;
        mag_b     = (is_signed && b[WIDTH-1]) ? (-b) : b;
    end

    // Sign correction applied in FIX.
    always_comb begin
        prod     = {acc_q, qr_q};
        prod_fix = neg_q_q ? (-prod) : prod;
        quo_fix  = neg_q_q ? (-qr_q) : qr_q;
        rem_fix  = neg_r_q ? (-acc_q) : acc_q;
    end

    md_iter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div   (is_div_q),
        .acc      (acc_q),
        .qr       (qr_q),
        .mag      (mag_b_q),
        .acc_next (acc_nx),
        .qr_next  (qr_nx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            qr_q     <= '0;
            mag_b_q  <= '0;
            a_orig_q <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            dz_q     <= 1'b0;
            busy     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else if (flush) begin
            // Cancel without touching HI/LO; a same-cycle start is dropped too.
            state_q <= IDLE;
            busy    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (op == OP_MTHI) begin
                            hi <= a;
                        end else if (op == OP_MTLO) begin
                            lo <= a;
                        end else if (is_md_op) begin
                            acc_q    <= '0;
                            qr_q     <= mag_a;
                            mag_b_q  <= mag_b;
                            a_orig_q <= a;
                            is_div_q <= is_div_op;
                            neg_q_q  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r_q  <= (op == OP_DIV) && a[WIDTH-1];
                            dz_q     <= is_div_op && (b == '0);
                            cnt_q    <= '0;
                            busy     <= 1'b1;
                            state_q  <= is_div_op ? DIV : MUL;
                        end
                    end
                end
                MUL, DIV: begin
                    acc_q <= acc_nx;
                    qr_q  <= qr_nx;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (!is_div_q) begin
                        {hi, lo} <= prod_fix;
                    end else if (dz_q) begin
                        // Divide by zero: all-ones quotient, dividend echoed into HI.
                        hi <= a_orig_q;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule : md_unit

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected HI/LO queued at issue, checked when busy falls.
module tb_md_unit;
    import md_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;
    md_result_t exp_q[$];
    logic busy_d = 1'b0;

    md_unit #(
        .WIDTH (32),
        .CNT_W (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a falling busy means a result (or cancellation) is presented.
    always @(negedge clk) begin
        md_result_t e;
        if (busy_d && !busy) begin
            if (exp_q.size() == 0) begin
                check("unexpected busy fall", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("result hi", 64'(hi), 64'(e.hi));
                check("result lo", 64'(lo), 64'(e.lo));
            end
        end
        busy_d = busy;
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(negedge clk);
        start = 1'b0; op = 3'b110;
    endtask

    // Counts busy cycles; optionally injects an ignored start or a flush at cycle n.
    task automatic wait_idle(input string name, input int exp_cyc, input int inj_at, input int flush_at);
        int n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (n == inj_at) begin
                start = 1'b1; op = OP_MULT; a = 32'h7FFF_FFFF; b = 32'h7FFF_FFFF;
            end
            if (n == flush_at) begin
                flush = 1'b1; start = 1'b1; op = OP_MTHI; a = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            start = 1'b0; flush = 1'b0; op = 3'b110;
        end
        check(name, 64'(n), 64'(exp_cyc));
    endtask

    task automatic run_md(input string name, input logic [2:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo);
        md_result_t e;
        e.hi = ehi; e.lo = elo;
        exp_q.push_back(e);
        issue(o, av, bv);
        wait_idle(name, 33, 0, 0);
    endtask

    initial begin
        md_result_t e;
        rst_n = 1'b0; start = 1'b0; op = 3'b110; a = '0; b = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_md("multu max busy", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_md("mult -3*5 busy", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_md("div -7/2 busy", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divu 7/0 busy", OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
        run_md("div min/-1 busy", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_md("div -7/0 busy", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

        // No-op encoding must not start anything.
        issue(3'b111, 32'd9, 32'd9);
        check("noop busy", 64'(busy), 64'd0);

        // MTHI then MULTU on the very next cycle, with an ignored start mid-op.
        e.hi = 32'd0; e.lo = 32'd12;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b1; op = OP_MTHI; a = 32'h1234_5678; b = '0;
        @(negedge clk);
        check("mthi hi", 64'(hi), 64'h1234_5678);
        check("mthi busy", 64'(busy), 64'd0);
        op = OP_MULTU; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0; op = 3'b110;
        wait_idle("multu 3*4 busy", 33, 10, 0);

        // MTLO, then a DIV cancelled by flush at cycle 15 (with a dropped MTHI).
        issue(OP_MTLO, 32'hAAAA_5555, 32'd0);
        check("mtlo lo", 64'(lo), 64'hAAAA_5555);
        e.hi = 32'd0; e.lo = 32'hAAAA_5555;
        exp_q.push_back(e);
        issue(OP_DIV, 32'd100, 32'd7);
        wait_idle("flush busy", 15, 0, 15);
        @(negedge clk);
        check("post flush hi", 64'(hi), 64'd0);

        // Asynchronous reset in the middle of a MULT.
        issue(OP_MTHI, 32'h0000_0055, 32'd0);
        check("mthi2 hi", 64'(hi), 64'h55);
        e.hi = 32'd0; e.lo = 32'd0;
        exp_q.push_back(e);
        issue(OP_MULT, 32'h0000_1234, 32'hFFFF_FFF0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst busy", 64'(busy), 64'd0);
        check("async rst hi", 64'(hi), 64'd0);
        check("async rst lo", 64'(lo), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_md_unit
